fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter sharing one synchronous FIFO between N producers.
//  - Each producer has a valid/ready channel.
//  - Grants one producer at a time and lets it write up to MAX_BURST consecutive words.
//  - Drives the FIFO wr_en/data_in and never writes into a full FIFO.
//  - Sits between the producer clients and the FIFO write side; the read side is untouched.
// PARAMETERS
//  N_REQ      4   number of producers (>=2)
//  DATA_W     16  FIFO word width
//  MAX_BURST  4   max consecutive words per grant (>=1; 1 = per-word round robin)
// PORTS
//  clk           in   1             clock, all logic on posedge
//  rst_n         in   1             async active-low reset
//  req_valid     in   N_REQ         producer i has a word ready
//  req_data      in   N_REQ*DATA_W  producer i word in slice [i*DATA_W +: DATA_W]
//  req_ready     out  N_REQ         word of producer i accepted this cycle
//  fifo_wr_en    out  1             FIFO write enable
//  fifo_data_in  out  DATA_W        FIFO write data
//  fifo_full     in   1             FIFO full, combinational from current occupancy
//  fifo_overflow in   1             FIFO overflow flag (monitor only)
//  gnt_valid     out  1             a producer currently holds or wins the grant
//  gnt_id        out  clog2(N_REQ)  index of that producer
//  err_overflow  out  1             sticky: fifo_overflow was ever seen high
// BEHAVIOUR
//  Registered state
//  - state {IDLE, BURST}, owner, rr_ptr, burst_cnt (clog2(MAX_BURST+1) bits), err_overflow.
//  - Async reset value of all registered state is 0: IDLE, owner=0, rr_ptr=0, burst_cnt=0, err_overflow=0.
//  - While rst_n=0, req_ready, fifo_wr_en and gnt_valid are forced to 0 combinationally.
//  Handshake
//  - A transfer happens when req_valid[i] && req_ready[i]. It is zero latency: fifo_wr_en=1 in the same cycle.
//  - Only the granted index can have req_ready high. At most one bit of req_ready is high per cycle.
//  - req_ready[g] = req_valid[g] && !fifo_full, so fifo_wr_en is never high while fifo_full=1.
//  - fifo_data_in = req_data slice of gnt_id when gnt_valid=1, else 0.
//  IDLE
//  - Winner is the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo N_REQ.
//  - If a winner exists: gnt_valid=1 and gnt_id=winner.
//  - If a winner exists and !fifo_full: write this cycle, owner<=winner, burst_cnt<=1.
//    - If MAX_BURST==1: stay IDLE and rr_ptr<=winner+1.
//    - Otherwise go to BURST.
//  - If a winner exists but fifo_full=1: no write, state unchanged, rr_ptr unchanged.
//  BURST
//  - gnt_valid=1 and gnt_id=owner. Other producers get no ready.
//  - Transfer: burst_cnt++. If burst_cnt+1==MAX_BURST, go to IDLE and rr_ptr<=owner+1 (wrap).
//  - req_valid[owner]=0: go to IDLE and rr_ptr<=owner+1. This cycle has no write.
//  - fifo_full=1 with req_valid[owner]=1: hold. No write, burst_cnt unchanged, owner keeps the grant.
//  - Burst end to next grant has no bubble: IDLE arbitrates and writes the cycle after.
//  Overflow
//  - err_overflow<=1 on any cycle with fifo_overflow=1. It clears only on reset.
//  - In a correct system err_overflow stays 0.
//  Reset mid-operation
//  - Any in-flight burst is abandoned. After release, arbitration restarts from index 0.
// TESTING (N_REQ=4, DATA_W=16, MAX_BURST=4, FIFO depth 8)
//  1. req_valid=4'b1111 held, reads keep FIFO below full
//     -> gnt_id sequence 0,0,0,0,1,1,1,1,2,... with fifo_wr_en=1 every cycle and no gap.
//  2. Only req_valid[2] set for 2 cycles, data 16'hA1/16'hA2
//     -> FIFO receives A1 then A2. Back to IDLE next cycle with rr_ptr=3.
//  3. Owner 1 mid-burst (burst_cnt=2) and fifo_full rises for 3 cycles
//     -> req_ready=0 and fifo_wr_en=0 for 3 cycles, owner stays 1, burst_cnt stays 2.
//     -> Writes resume on the cycle fifo_full falls; 2 more words, then grant passes on.
//  4. rr_ptr=3 with req_valid=4'b1001 -> gnt_id=3 first, then gnt_id=0.
//  5. rst_n pulsed low mid-burst -> fifo_wr_en=0 immediately.
//     -> After release with req_valid=4'b1110, gnt_id=1.
//  6. Force fifo_overflow=1 for one cycle -> err_overflow=1 next edge, held until reset.
//     Assertion: never (fifo_wr_en && fifo_full), never $countones(req_ready)>1.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N producers, the arbiter and the shared FIFO.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_data_in;
  logic                    fifo_full;
  logic                    fifo_overflow;
  logic                    gnt_valid;
  logic [ID_W-1:0]         gnt_id;
  logic                    err_overflow;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, fifo_full, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, gnt_valid, gnt_id, err_overflow
  );

  // Producers + FIFO side
  modport master (
    output req_valid, req_data, fifo_full, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, gnt_valid, gnt_id, err_overflow
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N producers share one FIFO write port, with
// bursts of up to MAX_BURST words per grant and zero-latency handshakes.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    owner, owner_n;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
  logic [CNT_W-1:0]   cnt_inc;
  logic               err_q;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    idx;
  logic               gnt_v;
  logic [ID_W-1:0]    gnt_i;
  logic               xfer;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Find the first valid producer at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = rr_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
      idx = next_id(idx);
    end
  end

  // Current grant, handshake and FIFO write outputs (forced idle in reset)
  always_comb begin
    gnt_v = (state == BURST) || win_found;
    gnt_i = (state == BURST) ? owner : (win_found ? win_id : '0);
    xfer  = gnt_v && bus.req_valid[gnt_i] && !bus.fifo_full;

    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.gnt_valid    = 1'b0;
    bus.gnt_id       = '0;
    bus.fifo_data_in = '0;
    if (rst_n) begin
      bus.gnt_valid  = gnt_v;
      bus.fifo_wr_en = xfer;
      if (xfer) bus.req_ready[gnt_i] = 1'b1;
      if (gnt_v) begin
        bus.gnt_id       = gnt_i;
        bus.fifo_data_in = bus.req_data[gnt_i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: start, extend, hold or release a burst
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    cnt_inc     = burst_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (xfer) begin
          owner_n     = win_id;
          burst_cnt_n = CNT_W'(1);
          if (MAX_BURST == 1) rr_ptr_n = next_id(win_id);
          else                state_n  = BURST;
        end
      end
      BURST: begin
        if (!bus.req_valid[owner]) begin
          state_n  = IDLE;
          rr_ptr_n = next_id(owner);
        end else if (xfer) begin
          burst_cnt_n = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state_n  = IDLE;
            rr_ptr_n = next_id(owner);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  // Sticky overflow monitor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (bus.fifo_overflow) err_q <= 1'b1;
  end

  assign bus.err_overflow = err_q;
endmodule
